// File: rtl/intt_stage.sv
// Inverse-NTT pipeline stage: Gentleman-Sande butterfly (u=a+b, v=(a-b)*zeta*2^-16)
// followed by a delay commutator that re-pairs results for the next inverse stage.
module intt_stage #(
  parameter int STAGE         = 0,
  parameter int NTT_STAGE_CNT = 7,
  parameter int DATA_WIDTH    = 12,
  parameter int Q             = 3329,
  parameter int MUL_LAT       = 3,
  parameter int AS_LAT        = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_en,
  input  logic [2*DATA_WIDTH-1:0]   in,
  output logic [NTT_STAGE_CNT-1:0]  rom_addr,
  input  logic [DATA_WIDTH-1:0]     rom_data,
  output logic                      out_en,
  output logic [2*DATA_WIDTH-1:0]   out
);

  localparam int W      = DATA_WIDTH;
  localparam int D      = (STAGE == NTT_STAGE_CNT - 1) ? 0 : (1 << STAGE);
  localparam int BF_LAT = 1 + AS_LAT + MUL_LAT;
  localparam int L      = BF_LAT + D;
  localparam int RW     = 16;
  localparam int MW     = RW + W + 2;

  // -Q^-1 mod 2^16 by Newton iteration (an odd q is its own inverse mod 8).
  function automatic logic [RW-1:0] neg_qinv(input int q);
    logic [RW-1:0] x;
    x = RW'(q);
    for (int i = 0; i < 5; i++) begin
      x = x * (RW'(2) - RW'(q) * x);
    end
    return (~x) + 1'b1;
  endfunction

  localparam logic [W:0]       Q_EXT    = (W+1)'(Q);
  localparam logic [MW-RW-1:0] Q_T      = (MW-RW)'(Q);
  localparam logic [RW-1:0]    QINV_NEG = neg_qinv(Q);

  logic [NTT_STAGE_CNT-1:0] pair_cnt_reg;
  logic [L-2:0]             vld_reg;
  logic [BF_LAT-2:0]        sel_reg;
  logic [2*W-1:0]           out_next;

  logic [W-1:0]   a_reg, b_reg, u_reg, diff_reg;
  logic [W-1:0]   u_dly [MUL_LAT-1];
  logic [2*W-1:0] prod_reg, prod_d_reg;
  logic [RW-1:0]  m_reg;

  logic [W:0]       sum_c;
  logic [W-1:0]     u_c, diff_c, v_c, a_c;
  logic [MW-1:0]    mont_c;
  logic [MW-RW-1:0] t_c;

  // Valid and commutator-phase bits travel alongside the data so that
  // gaps between frames and mid-frame resets need no extra bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pair_cnt_reg <= '0;
      rom_addr     <= '0;
      vld_reg      <= '0;
      sel_reg      <= '0;
      out_en       <= 1'b0;
      out          <= '0;
    end else begin
      pair_cnt_reg <= in_en ? pair_cnt_reg + 1'b1 : '0;
      rom_addr     <= pair_cnt_reg >> STAGE;
      vld_reg      <= {vld_reg[L-3:0], in_en};
      sel_reg      <= {sel_reg[BF_LAT-3:0], pair_cnt_reg[STAGE]};
      out_en       <= vld_reg[L-2];
      if (vld_reg[L-2]) begin
        out <= out_next;
      end
    end
  end

  always_comb begin
    sum_c  = {1'b0, a_reg} + {1'b0, b_reg};
    u_c    = (sum_c >= Q_EXT) ? W'(sum_c - Q_EXT) : sum_c[W-1:0];
    diff_c = (a_reg >= b_reg) ? (a_reg - b_reg)
                              : W'({1'b0, a_reg} + Q_EXT - {1'b0, b_reg});
  end

  // diff_reg lines up with rom_data, which arrives one cycle after rom_addr.
  always_ff @(posedge clk) begin
    a_reg      <= in[2*W-1:W];
    b_reg      <= in[W-1:0];
    u_reg      <= u_c;
    diff_reg   <= diff_c;
    prod_reg   <= (2*W)'(diff_reg) * (2*W)'(rom_data);
    m_reg      <= prod_reg[RW-1:0] * QINV_NEG;
    prod_d_reg <= prod_reg;
    u_dly[0]   <= u_reg;
    for (int i = 1; i < MUL_LAT - 1; i++) begin
      u_dly[i] <= u_dly[i-1];
    end
  end

  // Montgomery tail: (p + m*Q) is divisible by 2^16 and the quotient is < 2Q.
  always_comb begin
    mont_c = MW'(prod_d_reg) + MW'(m_reg) * MW'(Q_EXT);
    t_c    = mont_c[MW-1:RW];
    v_c    = (t_c >= Q_T) ? W'(t_c - Q_T) : W'(t_c);
  end

  assign a_c = u_dly[MUL_LAT-2];

  generate
    if (D == 0) begin : g_direct
      assign out_next = {a_c, v_c};
    end else begin : g_comm
      logic [W-1:0] bd_sr [D];
      logic [W-1:0] hi_sr [D];
      logic         sel;
      logic [W-1:0] lo, fifo_in;

      // sel=1 in the second half of each 2D block: A passes straight to the
      // low lane while delayed B is parked for the following half-block.
      assign sel      = sel_reg[BF_LAT-2];
      assign lo       = sel ? a_c : bd_sr[D-1];
      assign fifo_in  = sel ? bd_sr[D-1] : a_c;
      assign out_next = {hi_sr[D-1], lo};

      always_ff @(posedge clk) begin
        bd_sr[0] <= v_c;
        hi_sr[0] <= fifo_in;
        for (int i = 1; i < D; i++) begin
          bd_sr[i] <= bd_sr[i-1];
          hi_sr[i] <= hi_sr[i-1];
        end
      end
    end
  endgenerate

endmodule
